// File: rtl/alarm_input_pkg.sv
// Shared types and constants for the alarm input conditioner.
// Channel bit order is {passenger, driver, hidden, brake, ignition}.
package alarm_input_pkg;

  typedef enum logic {STABLE, PENDING} debounce_state_t;

  localparam int IGNITION_IDX  = 0;
  localparam int BRAKE_IDX     = 1;
  localparam int HIDDEN_IDX    = 2;
  localparam int DRIVER_IDX    = 3;
  localparam int PASSENGER_IDX = 4;

  // Doors idle closed (1); ignition, brake and hidden switch idle off (0).
  localparam logic [4:0] DEFAULT_RESET_LEVELS = 5'b11000;

  // Counter width able to hold 0..cycles.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_debounce_channel.sv
// One conditioned input bit: multi-flop synchronizer followed by a consecutive-sample debounce FSM.
// Optional edge pulses are built when ALARM_INPUT_EDGE_EN is defined.
module input_debounce_channel
  import alarm_input_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clock,
  input  logic systemReset,
  input  logic raw_i,
`ifdef ALARM_INPUT_EDGE_EN
  output logic rise_o,
  output logic fall_o,
`endif
  output logic clean_o
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  debounce_state_t        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (systemReset) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= RESET_LEVEL;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  // cnt tracks how many consecutive synchronized samples disagreed with clean_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync_s != clean_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            clean_d = sync_s;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (sync_s == clean_q) begin
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          clean_d = sync_s;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign clean_o = clean_q;

`ifdef ALARM_INPUT_EDGE_EN
  logic rise_q, fall_q;

  // Pulses register alongside clean_q so they line up with the new level.
  always_ff @(posedge clock) begin
    if (systemReset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= clean_d & ~clean_q;
      fall_q <= ~clean_d & clean_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/alarm_input_conditioner.sv
// Front-end for the anti-theft alarm: synchronizes and debounces each raw sensor level.
// Define ALARM_INPUT_EDGE_EN to add registered riseOut/fallOut pulse ports.
module alarm_input_conditioner
  import alarm_input_pkg::*;
#(
  parameter int                    NUM_INPUTS      = 5,
  parameter int                    SYNC_STAGES     = 2,
  parameter int                    DEBOUNCE_CYCLES = 4,
  parameter logic [NUM_INPUTS-1:0] RESET_LEVELS    = NUM_INPUTS'(DEFAULT_RESET_LEVELS)
) (
  input  logic                  clock,
  input  logic                  systemReset,
  input  logic [NUM_INPUTS-1:0] rawIn,
`ifdef ALARM_INPUT_EDGE_EN
  output logic [NUM_INPUTS-1:0] riseOut,
  output logic [NUM_INPUTS-1:0] fallOut,
`endif
  output logic [NUM_INPUTS-1:0] cleanOut
);

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
      input_debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (RESET_LEVELS[gi])
      ) u_chan (
        .clock      (clock),
        .systemReset(systemReset),
        .raw_i      (rawIn[gi]),
`ifdef ALARM_INPUT_EDGE_EN
        .rise_o     (riseOut[gi]),
        .fall_o     (fallOut[gi]),
`endif
        .clean_o    (cleanOut[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_alarm_input_conditioner.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized stimulus
// checked every cycle against a sliding-window reference model.
module tb_alarm_input_conditioner;

  localparam int         N   = 5;
  localparam int         S   = 2;
  localparam int         D   = 4;
  localparam logic [N-1:0] RST = 5'b11000;

  logic         clock = 1'b0;
  logic         systemReset = 1'b1;
  logic [N-1:0] rawIn = '0;
  logic [N-1:0] cleanOut;
`ifdef ALARM_INPUT_EDGE_EN
  logic [N-1:0] riseOut, fallOut;
`endif

  int errors = 0;
  int checks = 0;

  always #4 clock = ~clock;

  alarm_input_conditioner dut (
    .clock      (clock),
    .systemReset(systemReset),
    .rawIn      (rawIn),
`ifdef ALARM_INPUT_EDGE_EN
    .riseOut    (riseOut),
    .fallOut    (fallOut),
`endif
    .cleanOut   (cleanOut)
  );

  // Reference: a raw sample reaches the filter S edges later; the clean level flips
  // exactly when the last D filter inputs all disagree with it.
  logic [N-1:0] line_m [S];
  logic [N-1:0] win_m  [D];
  logic [N-1:0] m_clean, m_rise, m_fall, m_prev, m_fin, m_allmis;
  logic         m_valid = 1'b0;

  always @(posedge clock) begin
    if (systemReset) begin
      for (int i = 0; i < S; i++) line_m[i] = RST;
      for (int i = 0; i < D; i++) win_m[i] = RST;
      m_clean = RST;
      m_rise  = '0;
      m_fall  = '0;
      m_valid = 1'b1;
    end else begin
      m_fin = line_m[S-1];
      for (int i = D - 1; i > 0; i--) win_m[i] = win_m[i-1];
      win_m[0] = m_fin;
      m_allmis = '1;
      for (int i = 0; i < D; i++) m_allmis &= (win_m[i] ^ m_clean);
      m_prev  = m_clean;
      m_clean = m_clean ^ m_allmis;
      m_rise  = m_clean & ~m_prev;
      m_fall  = ~m_clean & m_prev;
      for (int i = S - 1; i > 0; i--) line_m[i] = line_m[i-1];
      line_m[0] = rawIn;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      checks++;
      if (cleanOut !== m_clean) begin
        errors++;
        $display("FAIL model_clean t=%0t got=%b want=%b", $time, cleanOut, m_clean);
      end
`ifdef ALARM_INPUT_EDGE_EN
      checks++;
      if (riseOut !== m_rise || fallOut !== m_fall) begin
        errors++;
        $display("FAIL model_edges t=%0t rise=%b/%b fall=%b/%b", $time, riseOut, m_rise, fallOut, m_fall);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with all raw low; doors drop after the full latency.
    systemReset = 1'b1;
    rawIn = 5'b00000;
    cyc(2);
    chk("reset_clean", 32'(cleanOut), 32'h18);
    systemReset = 1'b0;
    cyc(5);
    chk("doors_hold_5", 32'(cleanOut), 32'h18);
    cyc(1);
    chk("doors_fall_6", 32'(cleanOut), 32'h00);
`ifdef ALARM_INPUT_EDGE_EN
    chk("doors_fallout", 32'(fallOut), 32'h18);
    cyc(1);
    chk("doors_fallout_end", 32'(fallOut), 32'h00);
    cyc(2);
`else
    cyc(3);
`endif

    // 2: ignition rises after exactly six edges.
    rawIn[0] = 1'b1;
    cyc(5);
    chk("ign_hold_5", 32'(cleanOut[0]), 32'h0);
    cyc(1);
    chk("ign_rise_6", 32'(cleanOut[0]), 32'h1);
`ifdef ALARM_INPUT_EDGE_EN
    chk("ign_riseout", 32'(riseOut), 32'h01);
    cyc(1);
    chk("ign_riseout_end", 32'(riseOut), 32'h00);
`endif

    // 3: close doors, then a 3-cycle driver-door glitch must be rejected.
    rawIn[4:3] = 2'b11;
    cyc(8);
    chk("doors_closed", 32'(cleanOut), 32'h19);
    rawIn[3] = 1'b0;
    cyc(3);
    rawIn[3] = 1'b1;
    cyc(8);
    chk("glitch_rejected", 32'(cleanOut[3]), 32'h1);

    // 4: three lows, one high, then sustained low: falls 4 samples after re-low reaches filter.
    rawIn[3] = 1'b0;
    cyc(3);
    rawIn[3] = 1'b1;
    cyc(1);
    rawIn[3] = 1'b0;
    cyc(5);
    chk("restart_hold", 32'(cleanOut[3]), 32'h1);
    cyc(1);
    chk("restart_fall", 32'(cleanOut[3]), 32'h0);
    cyc(2);

    // 5: brake and hidden rise together.
    rawIn[2:1] = 2'b11;
    cyc(5);
    chk("pair_hold", 32'(cleanOut[2:1]), 32'h0);
    cyc(1);
    chk("pair_rise", 32'(cleanOut[2:1]), 32'h3);
    cyc(2);

    // 6: reset in mid-debounce discards the pending ignition change.
    rawIn[0] = 1'b0;
    cyc(8);
    chk("ign_low", 32'(cleanOut), 32'h16);
    rawIn[0] = 1'b1;
    cyc(4);
    systemReset = 1'b1;
    cyc(1);
    chk("midreset_clean", 32'(cleanOut), 32'h18);
`ifdef ALARM_INPUT_EDGE_EN
    chk("midreset_riseout", 32'(riseOut), 32'h00);
`endif
    systemReset = 1'b0;
    cyc(5);
    chk("post_reset_hold", 32'(cleanOut), 32'h18);
    cyc(1);
    chk("post_reset_update", 32'(cleanOut), 32'h17);

    // Randomized phase: mixed full-word and single-bit changes, occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 1) == 0) rawIn = N'($urandom);
      else rawIn[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) systemReset = 1'b1;
      cyc(1);
      systemReset = 1'b0;
      cyc($urandom_range(0, 7));
    end
    cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
